// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin packet arbiter: FSM state encoding
// and the width helper for port-index signals.
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // A single-port arbiter still carries a 1-bit index so port widths never collapse to zero.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: picks the lowest requesting index at or above ptr_i,
// otherwise wraps around to the lowest requesting index below ptr_i.
module rr_pick
    import rr_arbiter_pkg::*;
#(
    parameter int NumPorts = 4,
    localparam int IdxW = idx_width(NumPorts)
) (
    input  logic [NumPorts-1:0] req_i,
    input  logic [IdxW-1:0]     ptr_i,
    output logic                found_o,
    output logic [IdxW-1:0]     idx_o
);

    logic            hi_found;
    logic [IdxW-1:0] hi_idx;
    logic            lo_found;
    logic [IdxW-1:0] lo_idx;

    // Scan from the top down so the last hit in each half is its lowest index.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = NumPorts - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                if (IdxW'(i) >= ptr_i) begin
                    hi_found = 1'b1;
                    hi_idx   = IdxW'(i);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = IdxW'(i);
                end
            end
        end
        found_o = hi_found | lo_found;
        idx_o   = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Packet-level round-robin arbiter. One requester at a time owns the shared
// output for a whole packet; ownership passes on in round-robin order after
// the beat marked last has been transferred.
//
// Handshake: a beat moves on a port when valid and ready are both high at a
// rising clock edge. A source keeps valid, data and last stable until the beat
// moves. The arbiter passes the granted port straight through (out_valid
// follows in_valid[gnt], in_ready[gnt] follows out_ready), so there is no
// buffering and no extra latency once a grant is held.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int  NumPorts = 4,
    parameter type T        = logic [31:0],
    localparam int IdxW     = idx_width(NumPorts)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NumPorts-1:0] in_valid,
    output logic [NumPorts-1:0] in_ready,
    input  T                    in_data [NumPorts],
    input  logic [NumPorts-1:0] in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output T                    out_data,
    output logic                out_last,
    output logic [IdxW-1:0]     out_port,
    output state_e              dbg_state_o,
    output logic [IdxW-1:0]     dbg_ptr_o
);

    state_e          state_q;
    logic [IdxW-1:0] gnt_q;
    logic [IdxW-1:0] ptr_q;
    logic [IdxW-1:0] ptr_d;

    logic            pick_found;
    logic [IdxW-1:0] pick_idx;

    logic            sel_valid;
    logic            sel_last;
    T                sel_data;
    logic            xfer_last;

    rr_pick #(
        .NumPorts(NumPorts)
    ) u_pick (
        .req_i  (in_valid),
        .ptr_i  (ptr_q),
        .found_o(pick_found),
        .idx_o  (pick_idx)
    );

    // Route the granted requester's beat signals (compare-based so any NumPorts indexes cleanly).
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (gnt_q == IdxW'(i)) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[i];
            end
        end
    end

    // Packet end and the pointer that follows the current grant, wrapping at the top port.
    always_comb begin
        xfer_last = (state_q == BUSY) && sel_valid && out_ready && sel_last;
        ptr_d     = (gnt_q == IdxW'(NumPorts - 1)) ? '0 : gnt_q + IdxW'(1);
    end

    // Arbitration FSM: grant in IDLE, hold the grant in BUSY until the last beat moves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        gnt_q   <= pick_idx;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (xfer_last) begin
                        ptr_q   <= ptr_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output muxing: everything is zero outside BUSY, which also gives clean values in reset.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        out_port  = '0;
        in_ready  = '0;
        if (state_q == BUSY) begin
            out_valid = sel_valid;
            out_data  = sel_data;
            out_last  = sel_last;
            out_port  = gnt_q;
            for (int i = 0; i < NumPorts; i++) begin
                in_ready[i] = (gnt_q == IdxW'(i)) && out_ready;
            end
        end
    end

    assign dbg_state_o = state_q;
    assign dbg_ptr_o   = ptr_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: a 4-port instance for arbitration, packet
// locking, stalls and reset, plus a 1-port instance for the degenerate case.
module tb_rr_arbiter;
  import rr_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int W  = 35;  // {port[1:0], last, data[31:0]}
  localparam int W1 = 34;  // {port[0], last, data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 4-port DUT ----------------
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [31:0]  in_data [N];
  logic [N-1:0] in_last;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic [1:0]   out_port;
  state_e       dbg_state;
  logic [1:0]   dbg_ptr;

  rr_arbiter #(.NumPorts(N)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_port   (out_port),
    .dbg_state_o(dbg_state),
    .dbg_ptr_o  (dbg_ptr)
  );

  // ---------------- 1-port DUT ----------------
  logic [0:0]  v1;
  logic [0:0]  r1;
  logic [31:0] d1 [1];
  logic [0:0]  l1;
  logic        ov1;
  logic        or1;
  logic [31:0] od1;
  logic        ol1;
  logic [0:0]  op1;
  state_e      dbg1_state;
  logic [0:0]  dbg1_ptr;

  rr_arbiter #(.NumPorts(1)) u_one (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (v1),
    .in_ready   (r1),
    .in_data    (d1),
    .in_last    (l1),
    .out_valid  (ov1),
    .out_ready  (or1),
    .out_data   (od1),
    .out_last   (ol1),
    .out_port   (op1),
    .dbg_state_o(dbg1_state),
    .dbg_ptr_o  (dbg1_ptr)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;

  logic [W-1:0]  exp_q[$];
  logic [W1-1:0] exp1_q[$];
  int beat_cnt  = 0;
  int beat1_cnt = 0;
  int beat_cyc[$];
  int beat1_cyc[$];
  logic [W-1:0]  mon_got;
  logic [W-1:0]  mon_want;
  logic [W1-1:0] mon1_got;
  logic [W1-1:0] mon1_want;

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_got = {out_port, out_last, out_data};
      beat_cnt++;
      beat_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected actual=%h expected=<none>", mon_got);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          failures++;
          $display("FAIL beat actual=%h expected=%h", mon_got, mon_want);
        end
      end
      checks++;
      if (in_ready !== (4'b0001 << out_port)) begin
        failures++;
        $display("FAIL beat_in_ready actual=%b expected=%b", in_ready, 4'b0001 << out_port);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov1 && or1) begin
      mon1_got = {op1, ol1, od1};
      beat1_cnt++;
      beat1_cyc.push_back(cyc);
      checks++;
      if (exp1_q.size() == 0) begin
        failures++;
        $display("FAIL one_beat_unexpected actual=%h expected=<none>", mon1_got);
      end else begin
        mon1_want = exp1_q.pop_front();
        if (mon1_got !== mon1_want) begin
          failures++;
          $display("FAIL one_beat actual=%h expected=%h", mon1_got, mon1_want);
        end
      end
    end
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Wait until the 4-port monitor has seen n beats; returns just after a rising edge.
  task automatic wait_beats(input int n);
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (beat_cnt >= n) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_beats_timeout actual=%0d expected=%0d", beat_cnt, n);
  endtask

  // Drive one packet on port p; optional valid gap after the first beat.
  task automatic send_pkt(input int p, input int nbeats, input int gap, input logic [31:0] base);
    bit ok;
    for (int b = 0; b < nbeats; b++) begin
      in_valid[p] = 1'b1;
      in_data[p]  = base + 32'(b);
      in_last[p]  = (b == nbeats - 1);
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
        @(negedge clk);
        if (in_valid[p] && in_ready[p]) ok = 1'b1;
      end
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL send_timeout port=%0d beat=%0d actual=no_accept expected=accept", p, b);
      end
      @(posedge clk);
      #1;
      if (b == 0 && gap > 0 && nbeats > 1) begin
        in_valid[p] = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    in_valid[p] = 1'b0;
    in_last[p]  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int base;
  int base1;
  bit ok1;

  initial begin
    rst       = 1'b1;
    in_valid  = 4'hF;
    in_last   = 4'hF;
    for (int p = 0; p < N; p++) in_data[p] = 32'hDEAD_0000 + 32'(p);
    out_ready = 1'b1;
    v1        = 1'b1;
    d1[0]     = 32'hBEEF_0001;
    l1        = 1'b1;
    or1       = 1'b1;

    // Reset: outputs forced to zero even with every requester active.
    repeat (2) @(negedge clk);
    check("rst0_out_valid", out_valid, 0);
    check("rst0_out_last",  out_last,  0);
    check("rst0_out_port",  out_port,  0);
    check("rst0_out_data",  out_data,  0);
    check("rst0_in_ready",  in_ready,  0);
    check("rst0_state",     dbg_state, IDLE);
    check("rst0_ptr",       dbg_ptr,   0);
    check("rst0_one_valid", ov1,       0);
    check("rst0_one_data",  od1,       0);

    @(posedge clk);
    #1;
    in_valid = '0;
    in_last  = '0;
    v1       = 1'b0;
    l1       = 1'b0;
    rst      = 1'b0;

    // Requests 1001, single beats: port 0 then port 3, pointer back to 0.
    @(posedge clk);
    #1;
    in_data[0] = 32'h100;
    in_data[3] = 32'h103;
    in_last    = 4'hF;
    in_valid   = 4'b1001;
    exp_q.push_back({2'd0, 1'b1, 32'h100});
    exp_q.push_back({2'd3, 1'b1, 32'h103});
    @(negedge clk);
    check("lat_idle_valid", out_valid, 0);
    check("lat_idle_ready", in_ready,  0);
    @(negedge clk);
    check("lat_first_valid", out_valid, 1);
    check("lat_first_port",  out_port,  0);
    wait_beats(2);
    in_valid = '0;
    @(negedge clk);
    check("p1001_ptr",   dbg_ptr,   0);
    check("p1001_state", dbg_state, IDLE);

    // All four requesting single beats: 0,1,2,3,0 at one grant every 2 cycles.
    @(posedge clk);
    #1;
    base = beat_cnt;
    for (int p = 0; p < N; p++) in_data[p] = 32'h330 + 32'(p);
    in_last  = 4'hF;
    in_valid = 4'hF;
    exp_q.push_back({2'd0, 1'b1, 32'h330});
    exp_q.push_back({2'd1, 1'b1, 32'h331});
    exp_q.push_back({2'd2, 1'b1, 32'h332});
    exp_q.push_back({2'd3, 1'b1, 32'h333});
    exp_q.push_back({2'd0, 1'b1, 32'h330});
    wait_beats(base + 5);
    in_valid = '0;
    in_last  = '0;
    if (beat_cnt >= base + 5) begin
      for (int k = 1; k < 5; k++)
        check("rr_spacing", beat_cyc[base + k] - beat_cyc[base + k - 1], 2);
    end
    @(negedge clk);
    check("rr_ptr", dbg_ptr, 1);

    // Port 2 three-beat packet with a 2-cycle gap; port 1 waits for out_last.
    @(posedge clk);
    #1;
    base = beat_cnt;
    exp_q.push_back({2'd2, 1'b0, 32'h200});
    exp_q.push_back({2'd2, 1'b0, 32'h201});
    exp_q.push_back({2'd2, 1'b1, 32'h202});
    exp_q.push_back({2'd1, 1'b1, 32'h110});
    fork
      send_pkt(2, 3, 2, 32'h200);
    join_none
    @(posedge clk);
    #1;
    fork
      send_pkt(1, 1, 0, 32'h110);
    join_none
    wait_beats(base + 1);
    @(negedge clk);
    check("gap_out_valid", out_valid, 0);
    check("gap_out_port",  out_port,  2);
    check("gap_in_ready",  in_ready,  4'b0100);
    check("gap_state",     dbg_state, BUSY);
    wait_beats(base + 4);
    @(negedge clk);
    check("lock_ptr",   dbg_ptr,   2);
    check("lock_state", dbg_state, IDLE);

    // Port 1 stalled by out_ready=0 for three BUSY cycles.
    @(posedge clk);
    #1;
    base      = beat_cnt;
    out_ready = 1'b0;
    exp_q.push_back({2'd1, 1'b1, 32'h150});
    fork
      send_pkt(1, 1, 0, 32'h150);
    join_none
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data",  out_data,  32'h150);
      check("stall_out_port",  out_port,  1);
      check("stall_in_ready",  in_ready,  0);
      check("stall_state",     dbg_state, BUSY);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_beats(base + 1);

    // Reset pulse in the middle of a port-3 packet.
    @(posedge clk);
    #1;
    base       = beat_cnt;
    in_data[3] = 32'h300;
    in_last    = '0;
    in_valid   = 4'b1000;
    exp_q.push_back({2'd3, 1'b0, 32'h300});
    wait_beats(base + 1);
    in_data[3] = 32'h301;
    in_last[3] = 1'b1;
    out_ready  = 1'b0;
    @(negedge clk);
    check("pre_rst_port", out_port, 3);
    check("pre_rst_data", out_data, 32'h301);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_last",  out_last,  0);
    check("arst_out_port",  out_port,  0);
    check("arst_out_data",  out_data,  0);
    check("arst_in_ready",  in_ready,  0);
    check("arst_state",     dbg_state, IDLE);
    check("arst_ptr",       dbg_ptr,   0);
    in_valid = '0;
    in_last  = '0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    base       = beat_cnt;
    in_data[1] = 32'h410;
    in_data[3] = 32'h430;
    in_last    = 4'hF;
    in_valid   = 4'b1010;
    exp_q.push_back({2'd1, 1'b1, 32'h410});
    exp_q.push_back({2'd3, 1'b1, 32'h430});
    wait_beats(base + 2);
    in_valid = '0;
    in_last  = '0;

    // Single-port instance: back-to-back 2-beat packets.
    @(posedge clk);
    #1;
    base1 = beat1_cnt;
    exp1_q.push_back({1'b0, 1'b0, 32'h500});
    exp1_q.push_back({1'b0, 1'b1, 32'h501});
    exp1_q.push_back({1'b0, 1'b0, 32'h502});
    exp1_q.push_back({1'b0, 1'b1, 32'h503});
    v1 = 1'b1;
    for (int b = 0; b < 4; b++) begin
      d1[0] = 32'h500 + 32'(b);
      l1    = (b % 2 == 1);
      ok1   = 1'b0;
      for (int c = 0; c < 100 && !ok1; c++) begin
        @(negedge clk);
        if (v1[0] && r1[0]) ok1 = 1'b1;
      end
      if (!ok1) begin
        checks++;
        failures++;
        $display("FAIL one_send_timeout beat=%0d actual=no_accept expected=accept", b);
      end
      @(posedge clk);
      #1;
    end
    v1 = 1'b0;
    l1 = 1'b0;
    @(negedge clk);
    if (beat1_cnt >= base1 + 4) begin
      check("one_gap_b1", beat1_cyc[base1 + 1] - beat1_cyc[base1],     1);
      check("one_gap_b2", beat1_cyc[base1 + 2] - beat1_cyc[base1 + 1], 2);
      check("one_gap_b3", beat1_cyc[base1 + 3] - beat1_cyc[base1 + 2], 1);
    end else begin
      check("one_beats", beat1_cnt, base1 + 4);
    end
    check("one_ptr",   dbg1_ptr,   0);
    check("one_state", dbg1_state, IDLE);

    // ---------------- final report ----------------
    repeat (2) @(posedge clk);
    check("exp_q_empty",  exp_q.size(),  0);
    check("exp1_q_empty", exp1_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Overall time bound in case a wait is ever stuck outside a bounded loop.
  initial begin
    #100000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
